// File: rtl/reg_file_bypass.sv
// Register file with two registered read ports, optional write-to-read forwarding,
// optional hard-wired zero register and a saturating count of committed writes.
module reg_file_bypass #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 We,
    input  logic [ADDR_BITS-1:0] W_addr,
    input  logic [WIDTH-1:0]     W_data,
    input  logic                 Stall,
    input  logic [ADDR_BITS-1:0] A_addr,
    input  logic [ADDR_BITS-1:0] B_addr,
    output logic [WIDTH-1:0]     A_data,
    output logic [WIDTH-1:0]     B_data,
    output logic [15:0]          Wr_count
);

    localparam int          DEPTH   = 1 << ADDR_BITS;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] a_data_q, a_data_d;
    logic [WIDTH-1:0] b_data_q, b_data_d;
    logic [15:0]      wr_count_q, wr_count_d;
    logic             wr_commit;

    // Next value of one read register; the zero-register check outranks forwarding.
    function automatic logic [WIDTH-1:0] next_read(
        input logic [ADDR_BITS-1:0] addr,
        input logic [WIDTH-1:0]     held,
        input logic [WIDTH-1:0]     stored,
        input logic                 stall,
        input logic                 commit,
        input logic [ADDR_BITS-1:0] w_addr,
        input logic [WIDTH-1:0]     w_data
    );
        logic [WIDTH-1:0] value;
        value = stored;
        if (stall) begin
            value = held;
        end else if ((ZERO_REG != 0) && (addr == '0)) begin
            value = '0;
        end else if ((BYPASS != 0) && commit && (w_addr == addr)) begin
            value = w_data;
        end
        return value;
    endfunction

    always_comb begin
        wr_commit = We && !((ZERO_REG != 0) && (W_addr == '0));
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mem_d = mem_q;
        if (wr_commit) begin
            mem_d[W_addr] = W_data;
        end
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_commit && (wr_count_q != CNT_MAX)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_comb begin
        a_data_d = next_read(A_addr, a_data_q, mem_q[A_addr], Stall, wr_commit, W_addr, W_data);
        b_data_d = next_read(B_addr, b_data_q, mem_q[B_addr], Stall, wr_commit, W_addr, W_data);
    end

    // NOTE: the storage array is reset too, so every address reads 0 straight after reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            a_data_q   <= '0;
            b_data_q   <= '0;
            wr_count_q <= '0;
        end else begin
            a_data_q   <= a_data_d;
            b_data_q   <= b_data_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign A_data   = a_data_q;
    assign B_data   = b_data_q;
    assign Wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_bypass.sv
// Self-checking bench: a forwarding and a non-forwarding instance share stimulus;
// a behavioural model pushes expected outputs that are popped after each edge.
module tb_reg_file_bypass;

    localparam int W  = 32;
    localparam int AB = 5;

    typedef struct {
        logic [W-1:0] a_byp;
        logic [W-1:0] b_byp;
        logic [W-1:0] a_nb;
        logic [W-1:0] b_nb;
        logic [15:0]  cnt;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          we;
    logic [AB-1:0] w_addr;
    logic [W-1:0]  w_data;
    logic          stall;
    logic [AB-1:0] a_addr;
    logic [AB-1:0] b_addr;
    logic [W-1:0]  a_byp, b_byp, a_nb, b_nb;
    logic [15:0]   cnt_byp, cnt_nb;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [W-1:0] m_mem [1<<AB];
    logic [W-1:0] m_a_byp, m_b_byp, m_a_nb, m_b_nb;
    logic [15:0]  m_cnt;
    exp_t         sb_q [$];

    always #5 clock = ~clock;

    reg_file_bypass #(.WIDTH(W), .ADDR_BITS(AB), .ZERO_REG(1), .BYPASS(1)) dut_byp (
        .Clock(clock), .Reset(reset), .We(we), .W_addr(w_addr), .W_data(w_data),
        .Stall(stall), .A_addr(a_addr), .B_addr(b_addr),
        .A_data(a_byp), .B_data(b_byp), .Wr_count(cnt_byp)
    );

    reg_file_bypass #(.WIDTH(W), .ADDR_BITS(AB), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .Clock(clock), .Reset(reset), .We(we), .W_addr(w_addr), .W_data(w_data),
        .Stall(stall), .A_addr(a_addr), .B_addr(b_addr),
        .A_data(a_nb), .B_data(b_nb), .Wr_count(cnt_nb)
    );

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Model the coming edge from the current inputs, push the expectation,
    // then clock the DUTs and compare once the outputs have settled.
    task automatic step(input string tag);
        exp_t e;
        exp_t got;
        logic commit;
        commit = we && (w_addr != '0);
        if (reset) begin
            for (int i = 0; i < (1 << AB); i++) m_mem[i] = '0;
            m_a_byp = '0; m_b_byp = '0; m_a_nb = '0; m_b_nb = '0;
            m_cnt = '0;
        end else begin
            if (!stall) begin
                m_a_nb  = (a_addr == '0) ? '0 : m_mem[a_addr];
                m_b_nb  = (b_addr == '0) ? '0 : m_mem[b_addr];
                m_a_byp = (commit && a_addr == w_addr) ? w_data : m_a_nb;
                m_b_byp = (commit && b_addr == w_addr) ? w_data : m_b_nb;
            end
            if (commit) begin
                m_mem[w_addr] = w_data;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
        e.a_byp = m_a_byp; e.b_byp = m_b_byp;
        e.a_nb  = m_a_nb;  e.b_nb  = m_b_nb;
        e.cnt   = m_cnt;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        got = sb_q.pop_front();
        check({tag, ".a_byp"}, a_byp, got.a_byp);
        check({tag, ".b_byp"}, b_byp, got.b_byp);
        check({tag, ".a_nb"},  a_nb,  got.a_nb);
        check({tag, ".b_nb"},  b_nb,  got.b_nb);
        check({tag, ".cnt_byp"}, {16'd0, cnt_byp}, {16'd0, got.cnt});
        check({tag, ".cnt_nb"},  {16'd0, cnt_nb},  {16'd0, got.cnt});
    endtask

    task automatic drive(input logic rst, input logic wen, input logic [AB-1:0] wa,
                         input logic [W-1:0] wd, input logic stl,
                         input logic [AB-1:0] aa, input logic [AB-1:0] ba, input string tag);
        reset = rst; we = wen; w_addr = wa; w_data = wd; stall = stl;
        a_addr = aa; b_addr = ba;
        step(tag);
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; w_addr = '0; w_data = '0; stall = 1'b0;
        a_addr = '0; b_addr = '0;
        for (int i = 0; i < (1 << AB); i++) m_mem[i] = 'x;
        m_a_byp = 'x; m_b_byp = 'x; m_a_nb = 'x; m_b_nb = 'x; m_cnt = 'x;
        #2;

        // Reset for two cycles, then read 7 and 31
        drive(1, 0, 0, 0, 0, 7, 31, "rst0");
        drive(1, 0, 0, 0, 0, 7, 31, "rst1");
        drive(0, 0, 0, 0, 0, 7, 31, "rst_read");
        check("rst_a_exact", a_byp, 32'h0);
        check("rst_cnt_exact", {16'd0, cnt_byp}, 32'h0);

        // Write then read
        drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, "wr5");
        drive(0, 0, 0, 0, 0, 5, 5, "rd5");
        check("rd5_exact", a_byp, 32'hDEADBEEF);
        check("wr5_cnt_exact", {16'd0, cnt_byp}, 32'd1);

        // Same-cycle forwarding vs old contents
        drive(0, 1, 9, 32'h12345678, 0, 9, 9, "byp9");
        check("byp9_fwd", a_byp, 32'h12345678);
        check("byp9_nofwd", b_nb, 32'h0);
        drive(0, 0, 0, 0, 0, 9, 9, "rd9");

        // Zero register ignores writes and reads 0 even when written same cycle
        drive(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, "wr0");
        drive(0, 0, 0, 0, 0, 0, 0, "rd0");
        check("zero_cnt_exact", {16'd0, cnt_byp}, 32'd2);

        // Stall holds read registers while writes keep committing
        drive(0, 1, 12, 32'hA5A5A5A5, 0, 3, 3, "wr12");
        drive(0, 0, 0, 0, 0, 12, 12, "rd12");
        for (int i = 0; i < 3; i++) drive(0, 1, 12, 32'h1, 1, 12, 12, "stall");
        check("stall_hold", a_byp, 32'hA5A5A5A5);
        drive(0, 0, 0, 0, 0, 12, 12, "unstall");
        check("unstall_exact", a_byp, 32'h1);

        // Reset in the middle of a write burst
        drive(0, 1, 4, 32'h11, 0, 4, 12, "burst1");
        drive(1, 1, 6, 32'h22, 0, 6, 4, "burst2_rst");
        drive(0, 1, 8, 32'h33, 0, 4, 6, "burst3");
        check("burst_cnt_exact", {16'd0, cnt_byp}, 32'd1);
        drive(0, 0, 0, 0, 0, 6, 8, "burst_rd");

        // Random traffic over a small address range to force collisions
        for (int i = 0; i < 300; i++) begin
            logic [AB-1:0] ra;
            ra = AB'($urandom_range(0, 7));
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
                  AB'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0),
                  ra, ($urandom_range(0, 1) == 1) ? ra : AB'($urandom_range(0, 7)), "rand");
        end

        // Counter saturation
        drive(1, 0, 0, 0, 0, 0, 0, "sat_rst");
        for (int i = 0; i < 65540; i++) drive(0, 1, 3, i, 0, 3, 2, "sat");
        check("sat_exact", {16'd0, cnt_byp}, 32'h0000FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_file_bypass.md
REG_FILE_BYPASS -- requirements
Module: reg_file_bypass

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 32, which sets the data word width in bits.
REQ-002 The block SHALL have the parameter ADDR_BITS, default 5, which sets the register address width; the register count is 2^ADDR_BITS.
REQ-003 The block SHALL have the parameter ZERO_REG, default 1; when it is 1, register 0 reads as zero and ignores writes.
REQ-004 The block SHALL have the parameter BYPASS, default 1; when it is 1, a same-cycle write is forwarded to the read outputs.
REQ-005 Port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port We, input, 1 bit: write enable.
REQ-008 Port W_addr, input, ADDR_BITS wide: write address.
REQ-009 Port W_data, input, WIDTH wide: write data.
REQ-010 Port Stall, input, 1 bit: when high, the read output registers hold their values.
REQ-011 Port A_addr, input, ADDR_BITS wide: read port A address.
REQ-012 Port B_addr, input, ADDR_BITS wide: read port B address.
REQ-013 Port A_data, output, WIDTH wide: registered read data for port A.
REQ-014 Port B_data, output, WIDTH wide: registered read data for port B.
REQ-015 Port Wr_count, output, 16 bits: count of committed writes, saturating at 16'hFFFF.

Function
REQ-016 Storage SHALL be 2^ADDR_BITS words of WIDTH bits, written on the rising Clock edge when We=1 and Reset=0.
REQ-017 If ZERO_REG=1, a write to address 0 SHALL be discarded and SHALL NOT increment Wr_count.
REQ-018 Read latency SHALL be 1 cycle: the address sampled at edge N gives data on A_data/B_data after edge N.
REQ-019 When Stall=0, at each edge A_data SHALL load mem[A_addr]; when BYPASS=1, We=1 and W_addr==A_addr (a write that commits), A_data SHALL load W_data instead.
REQ-020 Port B SHALL follow the same rule as REQ-019, using B_addr.
REQ-021 When BYPASS=0, a same-cycle write SHALL NOT be forwarded: the read returns the old contents, and the new value is visible from the next read.
REQ-022 When ZERO_REG=1, a read of address 0 SHALL load 0, regardless of any same-cycle write to address 0.
REQ-023 When Stall=1, A_data and B_data SHALL hold their values; writes SHALL still commit and Wr_count SHALL still update.
REQ-024 Simultaneous reads of the same address on A and B SHALL return identical data.
REQ-025 Wr_count SHALL increment by 1 per committed write and SHALL saturate at 16'hFFFF, with no wrap.
REQ-026 An X-free design SHALL result: every output is driven from registers, with no combinational path from input to output.

Reset
REQ-027 While Reset=1 at an edge, all storage words, A_data, B_data and Wr_count SHALL be set to 0.
REQ-028 Reset SHALL take priority over We and Stall; a write presented in the reset cycle SHALL be lost.
REQ-029 Reset asserted mid-operation SHALL take effect at the next edge with no residual state; the first read after reset deassertion returns 0 for every address.

Verification
REQ-030 Scenario, reset: Reset=1 for 2 cycles, then A_addr=7, B_addr=31 -> A_data=0, B_data=0 and Wr_count=0 one cycle later.
REQ-031 Scenario, write then read: write 32'hDEADBEEF to address 5 at cycle 1; A_addr=5 at cycle 2 -> A_data=32'hDEADBEEF after cycle 2; Wr_count=1.
REQ-032 Scenario, bypass: in the same cycle, We=1, W_addr=9, W_data=32'h12345678, A_addr=B_addr=9 -> with BYPASS=1, A_data=B_data=32'h12345678 after that edge; with BYPASS=0 both read 0.
REQ-033 Scenario, zero register: write 32'hFFFFFFFF to address 0, read address 0 -> A_data=0 and Wr_count unchanged.
REQ-034 Scenario, stall: A_data=32'hA5A5A5A5; set Stall=1 for 3 cycles while writing 32'h1 to the addressed register -> A_data stays 32'hA5A5A5A5; the cycle after Stall drops, A_data=32'h1.
REQ-035 Scenario, reset during writes: write on cycles 1–3, assert Reset on cycle 2 -> after the reset edge all reads return 0; Wr_count=1 counting only the cycle 3 write; the cycle 2 write is lost.
